pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage CPU. It decides every cycle whether the PC and the IF/ID register advance, hold, or are flushed, and whether a bubble is injected into ID/EX. It tracks the multi-cycle MULT/DIV unit through a busy FSM and stalls dependent instructions. It also keeps a wrapping 7-bit issue count that matches the `total` field carried through the pipeline registers. It sits beside the IF/ID and ID/EX registers, and its outputs gate their write and reset paths.

---
 rtl/pipe_pkg.sv | 7 +
 rtl/muldiv_timer.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 59 +++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and widths for the pipeline sequencing controller.
package pipe_pkg;
    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
    localparam int REG_W   = 5;
    localparam int ISSUE_W = 7;
    localparam int STALL_W = 16;
endpackage

// File: rtl/muldiv_timer.sv
// muldiv_timer: busy FSM and down-counter tracking the multi-cycle MULT/DIV unit.
module muldiv_timer
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic last
);
    localparam int CW = $clog2(MD_CYCLES);

    md_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A start launches MD_CYCLES busy cycles: count MD_CYCLES-1 down to 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == MD_IDLE) begin
            state_n = start ? MD_BUSY : MD_IDLE;
            cnt_n   = start ? CW'(MD_CYCLES - 1) : cnt;
        end else begin
            state_n = (cnt == '0) ? MD_IDLE : MD_BUSY;
            cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
        end
    end

    assign busy = state == MD_BUSY;
    assign last = busy && cnt == '0;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble decisions, MULT/DIV interlock and issue/stall statistics.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int REG_W     = pipe_pkg::REG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               id_uses_rt,
    input  logic               id_muldiv,
    input  logic               id_reads_hilo,
    input  logic               ex_memread,
    input  logic [REG_W-1:0]   ex_rt,
    input  logic               ex_branch_taken,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               md_start,
    output logic               md_busy,
    output logic [ISSUE_W-1:0] issue_cnt,
    output logic [STALL_W-1:0] stall_cnt
);
    logic load_use, md_hazard, stall, issue;

    muldiv_timer #(.MD_CYCLES(MD_CYCLES)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .busy  (md_busy),
        .last  ()
    );

    assign load_use  = id_valid && ex_memread && ex_rt != '0 &&
                       (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    assign md_hazard = id_valid && md_busy && (id_reads_hilo || id_muldiv);
    // A taken branch makes the ID instruction wrong-path, so it never stalls.
    assign stall       = (load_use || md_hazard) && !ex_branch_taken;
    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign ifid_flush  = ex_branch_taken;
    assign idex_bubble = ex_branch_taken || stall;
    assign md_start    = id_valid && id_muldiv && !md_busy && !ex_branch_taken;
    assign issue       = id_valid && !stall && !ex_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue) issue_cnt <= issue_cnt + 1'b1;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
